goodness_accum: RTL and testbench
=================================

Name: goodness_accum

Overview:
Downstream consumer of the neuron core's POST_NEUR_MEM_BUS. It computes the Forward-Forward layer goodness G = sum over all OUTPUT_NEURON post-neurons of ReLU(mem)^2 during one post-neuron SRAM scan, using a 3-stage pipeline. It then compares G against a programmable threshold to give the positive/negative decision used by the FF-STDP training controller.

Parameters:
OUTPUT_NEURON, 256, total post-neurons per scan
POST_NEUR_PARALLEL, 4, lanes per bus beat (one SRAM word)
POST_NEUR_MEM_WIDTH, 12, signed two's-complement membrane width per lane
ACC_WIDTH, 32, goodness accumulator / output width

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
START  in  1  single-cycle pulse; clears and arms a new scan
MEM_VALID  in  1  POST_NEUR_MEM_BUS holds one valid group this cycle
POST_NEUR_MEM_BUS  in  POST_NEUR_MEM_WIDTH*POST_NEUR_PARALLEL  lane i at [i*W +: W]
GOOD_THR  in  ACC_WIDTH  unsigned decision threshold
BUSY  out  1  scan in progress (ACCUM or FLUSH)
DONE  out  1  one-cycle pulse when GOODNESS is final
GOODNESS  out  ACC_WIDTH  accumulated goodness
GOOD_ABOVE_THR  out  1  GOODNESS > GOOD_THR, valid from DONE onward
SAT  out  1  sticky, accumulator saturated during this scan

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - State goes to IDLE.
  - BUSY, DONE, SAT, GOOD_ABOVE_THR, GOODNESS, group counter and all pipeline regs/valid bits go to 0.
  - Reset mid-scan aborts the scan with no DONE.
- NGROUP = OUTPUT_NEURON/POST_NEUR_PARALLEL (64). The group counter is $clog2(NGROUP) bits; ceiling 1 when NGROUP=1.
- States:
  - IDLE: MEM_VALID is ignored. START -> ACCUM, and at that same edge GOODNESS, SAT, GOOD_ABOVE_THR, counter and pipeline valids clear to 0.
  - ACCUM: each cycle with MEM_VALID=1 accepts one group and increments the counter. Gaps (MEM_VALID=0) are allowed with no limit. Accepting group NGROUP-1 -> FLUSH, counter wraps to 0.
  - FLUSH: waits until all pipeline valid bits are 0, then pulses DONE and -> IDLE.
- Pipeline (per accepted beat at edge t):
  - S1 (reg @t): per lane r = (mem[W-1]) ? 0 : mem[W-2:0]; sq = r*r, width 2*(W-1) = 22 bits.
  - S2 (reg @t+1): lane sum of POST_NEUR_PARALLEL squares, width 22+$clog2(P) = 24 bits.
  - S3 (reg @t+2): GOODNESS <= sat(GOODNESS + lane_sum), zero-extended.
    - On overflow of ACC_WIDTH: GOODNESS = all-ones and SAT <= 1 (sticky until next START).
- Final-group timing: the last group is accepted at edge t; GOODNESS is final after edge t+2.
  - DONE=1 and GOOD_ABOVE_THR updated (registered compare) at edge t+3; DONE is high exactly one cycle.
  - BUSY drops with DONE.
  - GOODNESS, SAT and GOOD_ABOVE_THR hold until the next START.
- Boundary conditions:
  - START while BUSY: restart. Counter, accumulator, SAT and pipeline valids clear; in-flight beats are discarded; no DONE for the aborted scan.
  - START and MEM_VALID in the same cycle: START wins and that beat is discarded, in any state.
  - MEM_VALID during FLUSH: ignored.
  - mem = most-negative value (0x800): ReLU gives 0.
  - mem = 0x7FF: square is 4190209.
  - GOOD_THR is sampled combinationally at the DONE edge only.
- Throughput: one group per cycle, no backpressure. Worst case 64 consecutive beats, DONE 3 cycles after the last accepted beat.

Test Plan:
- Reset then START, 64 beats of all-zero mem -> DONE 3 cycles after beat 64; GOODNESS=0, GOOD_ABOVE_THR=0, SAT=0.
- All lanes mem=12'h040, GOOD_THR=1000000, back-to-back beats -> GOODNESS=64*64*256=1048576 (0x100000), GOOD_ABOVE_THR=1; DONE exactly once, BUSY high 64+3 cycles.
- Lanes {0x800, 0xFC0, 0x010, 0x7FF} every beat, random MEM_VALID gaps -> GOODNESS=64*(256+4190209)=268189760; DONE 3 cycles after the 64th valid beat regardless of gaps.
- ACC_WIDTH=20, all lanes 0x7FF -> SAT=1, GOODNESS=0xFFFFF, GOOD_ABOVE_THR=1 when GOOD_THR=0.
- START after 30 beats of 0x040, then 64 beats of 0x020 -> no DONE for the first scan; GOODNESS=262144.
- Beats presented in IDLE, START coincident with MEM_VALID, and RST_N low during FLUSH -> beats ignored/discarded; reset returns all outputs to 0 with no DONE.

Source files
------------

// File: rtl/goodness_accum.sv
// Forward-Forward layer goodness accumulator.
// Consumes one post-neuron SRAM scan from POST_NEUR_MEM_BUS. It computes
// G = sum(ReLU(mem)^2) over all post-neurons in a 3-stage pipeline. It then
// registers the decision G > GOOD_THR and pulses DONE when G is final.
module goodness_accum #(
  parameter int OUTPUT_NEURON       = 256,
  parameter int POST_NEUR_PARALLEL  = 4,
  parameter int POST_NEUR_MEM_WIDTH = 12,
  parameter int ACC_WIDTH           = 32
) (
  input  logic                                          CLK,
  input  logic                                          RST_N,
  input  logic                                          START,
  input  logic                                          MEM_VALID,
  input  logic [POST_NEUR_MEM_WIDTH*POST_NEUR_PARALLEL-1:0] POST_NEUR_MEM_BUS,
  input  logic [ACC_WIDTH-1:0]                          GOOD_THR,
  output logic                                          BUSY,
  output logic                                          DONE,
  output logic [ACC_WIDTH-1:0]                          GOODNESS,
  output logic                                          GOOD_ABOVE_THR,
  output logic                                          SAT
);

  localparam int W      = POST_NEUR_MEM_WIDTH;
  localparam int P      = POST_NEUR_PARALLEL;
  localparam int NGROUP = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int CNT_W  = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam int SQ_W   = 2 * (W - 1);
  localparam int SUM_W  = SQ_W + $clog2(P);
  localparam int EXT_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NGROUP - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 above_reg;
  logic                 sat_reg;
  logic [ACC_WIDTH-1:0] goodness_reg;

  logic                 s1_valid_reg;
  logic [SQ_W-1:0]      s1_sq_reg [P];
  logic                 s2_valid_reg;
  logic [SUM_W-1:0]     s2_sum_reg;

  logic [SQ_W-1:0]      sq_next [P];
  logic [SUM_W-1:0]     lane_sum_next;
  logic [EXT_W-1:0]     sum_ext;
  logic                 overflow;
  logic                 accept;

  // A beat is taken only while accumulating; a coincident START discards it.
  assign accept = (state_reg == ACCUM) && MEM_VALID && !START;

  // Per-lane ReLU and square. The sign bit selects zero, so 0x800 yields 0.
  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic [W-1:0] mem_lane;
    logic [W-2:0] relu;
    assign mem_lane    = POST_NEUR_MEM_BUS[gi*W +: W];
    assign relu        = mem_lane[W-1] ? '0 : mem_lane[W-2:0];
    assign sq_next[gi] = SQ_W'(relu) * SQ_W'(relu);
  end

  // Reduce the registered lane squares into one beat sum.
  always_comb begin
    lane_sum_next = '0;
    for (int i = 0; i < P; i++) begin
      lane_sum_next = lane_sum_next + SUM_W'(s1_sq_reg[i]);
    end
  end

  // The adder is one bit wider than either operand, so any carry out of ACC_WIDTH means saturation.
  assign sum_ext  = EXT_W'(goodness_reg) + EXT_W'(s2_sum_reg);
  assign overflow = |sum_ext[EXT_W-1:ACC_WIDTH];

  // Pipeline data registers for S1 (squares) and S2 (beat sum).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < P; i++) s1_sq_reg[i] <= '0;
      s2_sum_reg <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < P; i++) s1_sq_reg[i] <= sq_next[i];
      end
      if (s1_valid_reg) s2_sum_reg <= lane_sum_next;
    end
  end

  // Scan FSM, valid pipeline, saturating accumulator and threshold decision.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      above_reg    <= 1'b0;
      sat_reg      <= 1'b0;
      goodness_reg <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (START) begin
      // START restarts from any state. In-flight beats are dropped.
      state_reg    <= ACCUM;
      cnt_reg      <= '0;
      busy_reg     <= 1'b1;
      done_reg     <= 1'b0;
      above_reg    <= 1'b0;
      sat_reg      <= 1'b0;
      goodness_reg <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      s1_valid_reg <= accept;
      s2_valid_reg <= s1_valid_reg;
      if (s2_valid_reg) begin
        if (overflow) begin
          goodness_reg <= '1;
          sat_reg      <= 1'b1;
        end else begin
          goodness_reg <= sum_ext[ACC_WIDTH-1:0];
        end
      end
      case (state_reg)
        IDLE: ;
        ACCUM: begin
          if (MEM_VALID) begin
            if (cnt_reg == LAST_GROUP) begin
              cnt_reg   <= '0;
              state_reg <= FLUSH;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Pipeline drained: goodness_reg already holds the final sum.
          if (!s1_valid_reg && !s2_valid_reg) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            above_reg <= (goodness_reg > GOOD_THR);
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign BUSY           = busy_reg;
  assign DONE           = done_reg;
  assign GOODNESS       = goodness_reg;
  assign GOOD_ABOVE_THR = above_reg;
  assign SAT            = sat_reg;

endmodule

// File: tb/tb_goodness_accum.sv
// Directed testbench for goodness_accum.
// Expected scan results are queued when a scan is launched and checked when
// DONE appears. A second instance with a 20-bit accumulator covers saturation.
module tb_goodness_accum;

  localparam int W  = 12;
  localparam int P  = 4;
  localparam int NG = 64;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            mem_valid;
  logic [W*P-1:0]  mem_bus;
  logic [31:0]     good_thr;
  logic [19:0]     good_thr_b;

  logic            busy_a, done_a, above_a, sat_a;
  logic [31:0]     goodness_a;
  logic            busy_b, done_b, above_b, sat_b;
  logic [19:0]     goodness_b;

  goodness_accum #(.ACC_WIDTH(32)) dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start), .MEM_VALID(mem_valid),
    .POST_NEUR_MEM_BUS(mem_bus), .GOOD_THR(good_thr),
    .BUSY(busy_a), .DONE(done_a), .GOODNESS(goodness_a),
    .GOOD_ABOVE_THR(above_a), .SAT(sat_a)
  );

  goodness_accum #(.ACC_WIDTH(20)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start), .MEM_VALID(mem_valid),
    .POST_NEUR_MEM_BUS(mem_bus), .GOOD_THR(good_thr_b),
    .BUSY(busy_b), .DONE(done_b), .GOODNESS(goodness_b),
    .GOOD_ABOVE_THR(above_b), .SAT(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint g;
    bit     above;
    bit     sat;
  } exp_t;

  exp_t   exp_q[$];
  int     n_assert = 0;
  int     n_fail   = 0;
  int     cycle    = 0;
  int     done_cnt = 0;
  int     busy_cnt = 0;
  int     done_cycle = 0;
  int     last_beat_cycle = 0;
  bit     done_seen = 0;
  bit     prev_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference for one lane: ReLU then square.
  function automatic longint relu_sq(input logic [W-1:0] m);
    longint v;
    if (m[W-1]) return 0;
    v = longint'(m);
    return v * v;
  endfunction

  function automatic longint beat_sum(input logic [W*P-1:0] bus);
    longint s = 0;
    for (int i = 0; i < P; i++) s += relu_sq(bus[i*W +: W]);
    return s;
  endfunction

  // Queue the expected result of a full scan of identical beats.
  task automatic push_exp(input logic [W*P-1:0] bus, input longint thr);
    exp_t e;
    longint total;
    longint maxv;
    total = longint'(NG) * beat_sum(bus);
    maxv  = 64'hFFFF_FFFF;
    e.sat   = (total > maxv);
    e.g     = e.sat ? maxv : total;
    e.above = (e.g > thr);
    exp_q.push_back(e);
  endtask

  // One clock. Outputs are sampled 1 ns after the edge, and any DONE is scored.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    if (busy_a) busy_cnt++;
    if (done_a) begin
      done_cnt++;
      done_seen  = 1;
      done_cycle = cycle;
      check("done_single_cycle", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("goodness", {32'd0, goodness_a}, e.g);
        check("above_thr", {63'd0, above_a}, {63'd0, e.above});
        check("sat", {63'd0, sat_a}, {63'd0, e.sat});
        check("busy_drops_with_done", {63'd0, busy_a}, 64'd0);
      end
    end
    prev_done = done_a;
  endtask

  task automatic do_start(input bit with_valid, input logic [W*P-1:0] bus);
    start     = 1'b1;
    mem_valid = with_valid;
    mem_bus   = bus;
    step();
    start     = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [W*P-1:0] bus, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) step();
      end
      mem_valid = 1'b1;
      mem_bus   = bus;
      step();
      last_beat_cycle = cycle;
      mem_valid = 1'b0;
    end
  endtask

  // Bounded wait for DONE; also checks the 3-cycle latency after the last beat.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done_seen && n < 20) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, {63'd0, done_seen}, 64'd1);
    if (done_seen) check({tag, "_latency"}, 64'(done_cycle - last_beat_cycle), 64'd3);
  endtask

  initial begin
    int dc0;
    logic [W*P-1:0] bus;
    rst_n = 1'b0; start = 1'b0; mem_valid = 1'b0; mem_bus = '0;
    good_thr = '0; good_thr_b = '0;

    // Reset state
    step(); step();
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_done", {63'd0, done_a}, 64'd0);
    check("rst_goodness", {32'd0, goodness_a}, 64'd0);
    check("rst_above", {63'd0, above_a}, 64'd0);
    check("rst_sat", {63'd0, sat_a}, 64'd0);
    rst_n = 1'b1;
    step();

    // Scan of all-zero membranes
    bus = '0; good_thr = 0; done_seen = 0; done_cnt = 0;
    push_exp(bus, good_thr);
    do_start(0, '0);
    feed(NG, bus, 0);
    wait_done("zero");
    check("zero_done_count", 64'(done_cnt), 64'd1);

    // All lanes 0x040, back-to-back; BUSY lasts 64+3 cycles
    bus = {4{12'h040}}; good_thr = 1000000; done_seen = 0; done_cnt = 0;
    push_exp(bus, good_thr);
    busy_cnt = 0;
    do_start(0, '0);
    feed(NG, bus, 0);
    wait_done("h040");
    check("h040_value", {32'd0, goodness_a}, 64'd1048576);
    check("h040_busy_cycles", 64'(busy_cnt), 64'd67);
    step();
    check("h040_done_count", 64'(done_cnt), 64'd1);
    check("h040_hold", {32'd0, goodness_a}, 64'd1048576);

    // Mixed lanes {0x800,0xFC0,0x010,0x7FF} with random gaps; threshold equal to G
    bus = {12'h7FF, 12'h010, 12'hFC0, 12'h800}; good_thr = 268189760;
    done_seen = 0;
    push_exp(bus, good_thr);
    do_start(0, '0);
    feed(NG, bus, 1);
    wait_done("mixed");
    check("mixed_value", {32'd0, goodness_a}, 64'd268189760);
    check("mixed_above_at_equal", {63'd0, above_a}, 64'd0);

    // All lanes 0x7FF: the 20-bit instance saturates
    bus = {4{12'h7FF}}; good_thr = 0; good_thr_b = 0; done_seen = 0;
    push_exp(bus, good_thr);
    do_start(0, '0);
    feed(NG, bus, 0);
    wait_done("sat");
    check("satb_sat", {63'd0, sat_b}, 64'd1);
    check("satb_goodness", {44'd0, goodness_b}, 64'hFFFFF);
    check("satb_above", {63'd0, above_b}, 64'd1);

    // Restart mid-scan: the first scan yields no DONE
    done_seen = 0; done_cnt = 0;
    do_start(0, '0);
    feed(30, {4{12'h040}}, 0);
    bus = {4{12'h020}}; good_thr = 300000;
    push_exp(bus, good_thr);
    do_start(0, '0);
    feed(NG, bus, 0);
    wait_done("restart");
    check("restart_value", {32'd0, goodness_a}, 64'd262144);
    check("restart_done_count", 64'(done_cnt), 64'd1);

    // Beats in IDLE are ignored
    dc0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1'b1; mem_bus = {4{12'h7FF}};
      step();
    end
    mem_valid = 1'b0;
    check("idle_goodness_held", {32'd0, goodness_a}, 64'd262144);
    check("idle_busy", {63'd0, busy_a}, 64'd0);
    check("idle_no_done", 64'(done_cnt), 64'(dc0));

    // START with a coincident beat: that beat is discarded
    bus = {4{12'h010}}; good_thr = 0; done_seen = 0;
    push_exp(bus, good_thr);
    do_start(1, {4{12'h7FF}});
    feed(NG, bus, 0);
    wait_done("coincident");
    check("coincident_value", {32'd0, goodness_a}, 64'd65536);

    // MEM_VALID during FLUSH, then reset during FLUSH: no DONE, all outputs cleared
    dc0 = done_cnt;
    do_start(0, '0);
    feed(NG, {4{12'h040}}, 0);
    mem_valid = 1'b1; mem_bus = {4{12'h7FF}};
    step();
    mem_valid = 1'b0;
    check("flush_busy", {63'd0, busy_a}, 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("flushrst_busy", {63'd0, busy_a}, 64'd0);
    check("flushrst_done", {63'd0, done_a}, 64'd0);
    check("flushrst_goodness", {32'd0, goodness_a}, 64'd0);
    check("flushrst_above", {63'd0, above_a}, 64'd0);
    check("flushrst_sat", {63'd0, sat_a}, 64'd0);
    for (int i = 0; i < 6; i++) step();
    check("flushrst_no_done", 64'(done_cnt), 64'(dc0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
